// File: rtl/reg_dump_unit.sv
// Walks the masked registers of a register file and streams each one out with a running checksum.
// Two cycles per word (READ then SEND); SEND holds its word until OutReady, and unselected registers cost no cycles.
module reg_dump_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2**ADDR_W-1:0] mask,
  output logic [ADDR_W-1:0]    RdAddr,
  input  logic [DATA_W-1:0]    RdData,
  output logic [DATA_W-1:0]    OutData,
  output logic [ADDR_W-1:0]    OutAddr,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic                 OutLast,
  output logic                 Busy,
  output logic                 Done,
  output logic [DATA_W-1:0]    Checksum
);

  localparam int N = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t            state;
  logic [N-1:0]      mask_q;
  logic [ADDR_W-1:0] idx;

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [ADDR_W:0] find_from(input logic [N-1:0] m, input int from);
    logic [ADDR_W:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i] && i >= from) r = {1'b1, ADDR_W'(i)};
    end
    return r;
  endfunction

  logic [ADDR_W:0] first_hit;
  logic [ADDR_W:0] next_hit;

  assign first_hit = find_from(mask, 0);
  assign next_hit  = find_from(mask_q, int'(idx) + 1);

  assign RdAddr = (state == READ || state == SEND) ? idx : '0;
  assign Busy   = (state == READ || state == SEND);
  assign Done   = (state == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mask_q   <= '0;
      idx      <= '0;
      OutData  <= '0;
      OutAddr  <= '0;
      OutValid <= 1'b0;
      OutLast  <= 1'b0;
      Checksum <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            Checksum <= '0;
            if (|mask) begin
              mask_q <= mask;
              idx    <= first_hit[ADDR_W-1:0];
              state  <= READ;
            end else begin
              state  <= DONE;
            end
          end
        end
        READ: begin
          // Word is a snapshot of the register file at this edge.
          OutData  <= RdData;
          OutAddr  <= idx;
          Checksum <= Checksum + RdData;
          OutLast  <= ~next_hit[ADDR_W];
          OutValid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (OutReady) begin
            OutValid <= 1'b0;
            if (OutLast) begin
              state <= DONE;
            end else begin
              idx   <= next_hit[ADDR_W-1:0];
              state <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed and randomized dumps against a queue-based reference of the expected word stream and checksum.
module tb_reg_dump_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  mask;
  logic [2:0]  RdAddr;
  logic [15:0] RdData;
  logic [15:0] OutData;
  logic [2:0]  OutAddr;
  logic        OutValid;
  logic        OutReady;
  logic        OutLast;
  logic        Busy;
  logic        Done;
  logic [15:0] Checksum;

  logic [15:0] regs [8];

  int checks   = 0;
  int failures = 0;

  assign RdData = regs[RdAddr];

  reg_dump_unit #(.DATA_W(16), .ADDR_W(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .mask     (mask),
    .RdAddr   (RdAddr),
    .RdData   (RdData),
    .OutData  (OutData),
    .OutAddr  (OutAddr),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutLast  (OutLast),
    .Busy     (Busy),
    .Done     (Done),
    .Checksum (Checksum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one dump; the expected stream is every selected register in ascending address order.
  task automatic dump(input logic [7:0] m, input int stall, input bit rnd_ready,
                      input int exp_cyc, input bit repulse, input bit scribble);
    logic [15:0] q_dat[$];
    logic [2:0]  q_addr[$];
    logic [15:0] sum;
    logic [15:0] cap_dat;
    logic [2:0]  cap_addr;
    logic        cap_last;
    bit          have;
    bit          pulsed;
    int          wait_cnt;
    int          done_cyc;
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        q_dat.push_back(regs[i]);
        q_addr.push_back(3'(i));
        sum = sum + regs[i];
      end
    end
    have = 0; pulsed = 0; wait_cnt = 0; done_cyc = -1;
    cap_dat = '0; cap_addr = '0; cap_last = 1'b0;
    @(negedge clock);
    start = 1'b1; mask = m; OutReady = 1'b0;
    @(negedge clock);
    start = 1'b0; mask = 8'($urandom);
    for (int c = 0; c < 400 && done_cyc < 0; c++) begin
      if (c > 0) @(negedge clock);
      if (start) start = 1'b0;
      if (Done) begin
        done_cyc = c;
        check("valid_in_done", OutValid, 1'b0);
        check("busy_in_done", Busy, 1'b0);
      end else if (OutValid) begin
        check("busy_in_send", Busy, 1'b1);
        if (!have) begin
          have = 1; cap_dat = OutData; cap_addr = OutAddr; cap_last = OutLast;
          wait_cnt = rnd_ready ? int'($urandom_range(0, 3)) : stall;
        end else begin
          check("stall_data", OutData, cap_dat);
          check("stall_addr", OutAddr, cap_addr);
          check("stall_last", OutLast, cap_last);
        end
        if (repulse && !pulsed && OutAddr == 3'd2) begin
          start = 1'b1; mask = 8'h01; pulsed = 1;
        end
        if (wait_cnt > 0) begin
          OutReady = 1'b0;
          wait_cnt--;
        end else begin
          OutReady = 1'b1;
          check("word_expected", q_addr.size() != 0, 1'b1);
          if (q_addr.size() != 0) begin
            check("word_addr", OutAddr, q_addr[0]);
            check("word_data", OutData, q_dat[0]);
            check("word_last", OutLast, q_addr.size() == 1);
            void'(q_addr.pop_front());
            void'(q_dat.pop_front());
          end
          if (scribble) regs[OutAddr] = 16'($urandom);
          have = 0;
        end
      end else begin
        OutReady = 1'($urandom_range(0, 1));
      end
    end
    check("done_seen", done_cyc >= 0, 1'b1);
    if (exp_cyc >= 0) check("dump_cycles", done_cyc, exp_cyc);
    check("words_left", q_addr.size(), 0);
    check("checksum", Checksum, sum);
    @(negedge clock);
    start = 1'b0;
    check("done_single", Done, 1'b0);
    check("idle_busy", Busy, 1'b0);
    check("idle_valid", OutValid, 1'b0);
    check("idle_rdaddr", RdAddr, 3'd0);
    check("checksum_hold", Checksum, sum);
  endtask

  initial begin
    bit found;
    reset = 1'b1; start = 1'b0; mask = '0; OutReady = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = 16'h1000 + 16'(i);

    repeat (2) @(negedge clock);
    check("rst_valid", OutValid, 1'b0);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_last", OutLast, 1'b0);
    check("rst_data", OutData, 16'h0);
    check("rst_addr", OutAddr, 3'd0);
    check("rst_cksum", Checksum, 16'h0);
    check("rst_rdaddr", RdAddr, 3'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_after_rst", Busy, 1'b0);

    // Full mask at full throughput: 8 words, 16 cycles, known checksum.
    dump(8'hFF, 0, 0, 16, 0, 0);
    check("cksum_801c", Checksum, 16'h801C);

    // Sparse mask with a 3-cycle stall on every word.
    dump(8'hA4, 3, 0, 3 * (2 + 3), 0, 0);

    // Empty mask: Done right after start, no words, checksum cleared.
    dump(8'h00, 0, 0, 0, 0, 0);
    check("cksum_empty", Checksum, 16'h0);

    // Checksum wraps modulo 2**16.
    regs[0] = 16'hFFFF; regs[1] = 16'h0002;
    dump(8'h03, 0, 0, 4, 0, 0);
    check("cksum_wrap", Checksum, 16'h0001);

    // A start pulse during SEND must not disturb the running dump.
    for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
    dump(8'hFF, 0, 0, 16, 1, 0);

    // Reset while word 3 is being offered abandons the dump immediately.
    @(negedge clock);
    start = 1'b1; mask = 8'hFF; OutReady = 1'b1;
    @(negedge clock);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (OutValid && OutAddr == 3'd3) found = 1;
      else @(negedge clock);
    end
    check("reached_addr3", found, 1'b1);
    OutReady = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midrst_valid", OutValid, 1'b0);
    check("midrst_busy", Busy, 1'b0);
    check("midrst_done", Done, 1'b0);
    @(negedge clock);
    check("midrst_done2", Done, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check("postrst_done", Done, 1'b0);
    dump(8'hFF, 0, 0, 16, 0, 0);

    // Randomized masks, contents and consumer backpressure, with writes to already-dumped registers.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
      dump(8'($urandom), 0, 1, -1, 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_dump_unit.md
REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register data width.
REQ-002 SHALL have parameter ADDR_W, default 3, register address width; register count is 2**ADDR_W (8 by default).
REQ-003 SHALL have one clock and an asynchronous, active-high reset: port clock (input, 1, rising-edge clock) and port reset (input, 1, asynchronous active-high reset).
REQ-004 start  input  1  single-cycle request to begin a dump.
REQ-005 mask  input  2**ADDR_W  set bits select the registers to dump; sampled with start.
REQ-006 RdAddr  output  ADDR_W  address driven to the register file read port.
REQ-007 RdData  input  DATA_W  combinational read data returned for RdAddr.
REQ-008 OutData  output  DATA_W  dumped register value.
REQ-009 OutAddr  output  ADDR_W  index of the register in OutData.
REQ-010 OutValid  output  1  OutData/OutAddr/OutLast valid.
REQ-011 OutReady  input  1  consumer accepts the word.
REQ-012 OutLast  output  1  marks the final word of the dump.
REQ-013 Busy  output  1  high while the dump is in progress.
REQ-014 Done  output  1  one-cycle pulse when the dump completes.
REQ-015 Checksum  output  DATA_W  modulo-2**DATA_W sum of dumped words.

Function
REQ-016 SHALL implement states IDLE, READ, SEND and DONE.
REQ-017 IDLE: Busy=0, OutValid=0; RdAddr=0.
REQ-018 IDLE with start=1 and mask!=0: latch mask, clear Checksum, set idx to the lowest set bit, go to READ.
REQ-019 IDLE with start=1 and mask==0: clear Checksum, go to DONE; no word is emitted.
REQ-020 start SHALL be ignored in READ, SEND and DONE.
REQ-021 RdAddr SHALL equal the registered idx in READ and SEND.
REQ-022 READ lasts exactly one cycle; at its closing edge: OutData<=RdData, OutAddr<=idx, Checksum<=Checksum+RdData with carry discarded, OutLast<=1 iff idx is the highest set bit of the latched mask, OutValid<=1; go to SEND.
REQ-023 SEND: OutData, OutAddr and OutLast SHALL hold stable and OutValid SHALL stay 1 until a rising edge with OutValid&&OutReady.
REQ-024 On handshake with OutLast=0: OutValid<=0, idx<=next set bit above idx, go to READ.
REQ-025 On handshake with OutLast=1: OutValid<=0, go to DONE.
REQ-026 Unselected registers SHALL cost zero cycles; next-set-bit search is combinational.
REQ-027 DONE lasts one cycle with Done=1, then returns to IDLE; Checksum holds until the next accepted start.
REQ-028 Latency: start sampled at edge k gives OutValid=1 after edge k+1; minimum 2 cycles per word with OutReady held high.
REQ-029 Busy=1 in READ and SEND, 0 in IDLE and DONE.
REQ-030 Each word SHALL be a snapshot at its READ edge; writes to the register file during a dump are not coherent across words, and a write to an already-dumped register SHALL NOT be re-emitted.

Reset
REQ-031 reset=1 SHALL immediately force IDLE, with OutValid=0, OutLast=0, Busy=0, Done=0, OutData=0, OutAddr=0, Checksum=0, idx=0 and latched mask=0.
REQ-032 Reset mid-dump SHALL abandon the dump with no Done pulse; the next start SHALL begin afresh.

Verification
REQ-033 r0..r7=16'h1000+i, mask=8'hFF, OutReady=1 -> 8 words with OutAddr 0..7 in order, OutLast on addr 7 only, Done one pulse, Checksum=16'h801C, 16 cycles from first READ to DONE.
REQ-034 mask=8'hA4 with OutReady low 3 cycles per word -> only addrs 2, 5, 7 emitted; data stable while stalled; OutLast with addr 7.
REQ-035 mask=8'h00 start -> Done pulse next cycle, OutValid never high, Checksum=0.
REQ-036 r0=16'hFFFF, r1=16'h0002, mask=8'h03 -> Checksum=16'h0001.
REQ-037 reset asserted in SEND at addr 3 -> OutValid and Busy low without a clock edge, no Done; a new start with mask=8'hFF restarts at addr 0.
REQ-038 start re-pulsed with mask=8'h01 during SEND of a mask=8'hFF dump -> ignored; all 8 words still emitted.
